// File: rtl/fft64_reorder_if.sv
// Stream bundle for fft64_reorder: bit-reversed pairs in,
// natural-order bin pairs out.
interface fft64_reorder_if #(
  parameter int width = 11
);
  logic             valid_i;
  logic [width-1:0] ar;
  logic [width-1:0] ai;
  logic [width-1:0] br;
  logic [width-1:0] bi;
  logic             valid_o;
  logic             sof_o;
  logic [5:0]       bin_o;
  logic [width-1:0] xr;
  logic [width-1:0] xi;
  logic [width-1:0] yr;
  logic [width-1:0] yi;

  modport slave (
    input  valid_i, ar, ai, br, bi,
    output valid_o, sof_o, bin_o, xr, xi, yr, yi
  );

  modport master (
    output valid_i, ar, ai, br, bi,
    input  valid_o, sof_o, bin_o, xr, xi, yr, yi
  );
endinterface

// File: rtl/fft64_reorder.sv
// 64-point FFT output unscrambler: ping-pong banks turn the
// bit-reversed pair stream into natural bin order.
module fft64_reorder #(
  parameter int width = 11
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ce,
  fft64_reorder_if.slave  bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;
  localparam int         DW     = 4 * width;

  logic [DW-1:0] r_mem [64];
  logic [4:0]    r_wcnt;
  logic [4:0]    r_rcnt;
  logic          r_wb;
  logic          r_rb;
  logic [1:0]    r_full;
  logic [0:0]    r_state;
  logic          r_valid;
  logic          r_sof;
  logic [5:0]    r_bin;
  logic [DW-1:0] r_data;

  logic          w_wr;
  logic          w_rd;
  logic [5:0]    w_waddr;
  logic [5:0]    w_raddr;
  logic [1:0]    w_full_nxt;

  function automatic logic [4:0] rev5(input logic [4:0] v);
    rev5 = {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  assign w_wr    = ce && bus.valid_i;
  assign w_rd    = ce && (r_state == S_READ);
  assign w_waddr = {r_wb, rev5(r_wcnt)};
  assign w_raddr = {r_rb, r_rcnt};

  // a completed write wins over a finishing read of the same bank
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd && r_rcnt == 5'd31)
      w_full_nxt[r_rb] = 1'b0;
    if (w_wr && r_wcnt == 5'd31)
      w_full_nxt[r_wb] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_wr)
      r_mem[w_waddr] <= {bus.ar, bus.ai, bus.br, bus.bi};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wcnt  <= 5'd0;
      r_rcnt  <= 5'd0;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_full  <= 2'b00;
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_bin   <= 6'd0;
      r_data  <= '0;
    end else if (ce) begin
      r_full <= w_full_nxt;
      if (bus.valid_i) begin
        r_wcnt <= r_wcnt + 5'd1;
        if (r_wcnt == 5'd31)
          r_wb <= ~r_wb;
      end
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_sof   <= 1'b0;
          // r_rb always points at the oldest frame
          if (r_full[r_rb]) begin
            r_state <= S_READ;
            r_rcnt  <= 5'd0;
          end
        end
        S_READ: begin
          r_valid <= 1'b1;
          r_sof   <= (r_rcnt == 5'd0);
          r_bin   <= {r_rcnt, 1'b0};
          r_data  <= r_mem[w_raddr];
          r_rcnt  <= r_rcnt + 5'd1;
          if (r_rcnt == 5'd31) begin
            r_rb <= ~r_rb;
            if (!r_full[~r_rb])
              r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.sof_o   = r_sof;
  assign bus.bin_o   = r_bin;
  assign bus.xr      = r_data[4*width-1 -: width];
  assign bus.xi      = r_data[3*width-1 -: width];
  assign bus.yr      = r_data[2*width-1 -: width];
  assign bus.yi      = r_data[width-1 -: width];
endmodule

// File: tb/tb_fft64_reorder.sv
// Scoreboard bench for fft64_reorder: scrambled frames in,
// natural-order beats compared as they come out.
module tb_fft64_reorder;
  localparam int W = 11;

  typedef struct packed {
    logic         sof;
    logic [5:0]   bin;
    logic [W-1:0] xr;
    logic [W-1:0] xi;
    logic [W-1:0] yr;
    logic [W-1:0] yi;
  } beat_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ce  = 1'b0;

  fft64_reorder_if #(.width(W)) bus();

  fft64_reorder #(.width(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .ce  (ce),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int    checks = 0;
  int    passed = 0;
  beat_t sb[$];
  int    tl[$];

  function automatic int rev5(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++)
      r |= ((k >> i) & 1) << (4 - i);
    return r;
  endfunction

  function automatic beat_t mk(input int b, input int off);
    beat_t e;
    e.sof = (b == 0);
    e.bin = 6'(b);
    e.xr  = W'(b + off);
    e.xi  = W'(-(b + off));
    e.yr  = W'(b + 1 + off);
    e.yi  = W'(-(b + 1 + off));
    return e;
  endfunction

  function automatic beat_t obs();
    return {bus.sof_o, bus.bin_o, bus.xr, bus.xi, bus.yr, bus.yi};
  endfunction

  // drives nfr frames; only complete frames enter the scoreboard
  task automatic drive(input int nfr, input int gap, input int npairs,
                       input int off0, input bit ce_hole);
    for (int f = 0; f < nfr; f++) begin
      int off = off0 + 100 * f;
      if (npairs == 32)
        for (int b = 0; b < 64; b += 2)
          sb.push_back(mk(b, off));
      for (int k = 0; k < npairs; k++) begin
        int b = 2 * rev5(k);
        @(negedge CLK);
        if (ce_hole) ce = 1'b1;
        bus.valid_i = 1'b1;
        bus.ar = W'(b + off);
        bus.ai = W'(-(b + off));
        bus.br = W'(b + 1 + off);
        bus.bi = W'(-(b + 1 + off));
        if (k == npairs - 1) tl.push_back(cyc + 1);
        if (ce_hole && k == 10)
          repeat (3) begin
            @(negedge CLK);
            ce = 1'b0;
            bus.ar = '1;
            bus.ai = '1;
            bus.br = '1;
            bus.bi = '1;
          end
        if (k < npairs - 1)
          repeat (gap) begin
            @(negedge CLK);
            bus.valid_i = 1'b0;
          end
      end
    end
    @(negedge CLK);
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    ce  = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.valid_o !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", bus.valid_o);
    else passed++;
    checks++;
    if (obs() !== '0)
      $display("FAIL reset_outs: got %h want 0", obs());
    else passed++;
    RST = 1'b0;
    ce  = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single();
    int n = 0, first = -1, prev = -1, gaps = 0;
    beat_t o, e;
    tl.delete();
    fork
      drive(1, 0, 32, 0, 1'b0);
      for (int i = 0; i < 300 && n < 32; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL single_beat %0d: got %h want %h", n, o, e);
          else passed++;
          if (first < 0) first = cyc;
          else if (cyc != prev + 1) gaps++;
          prev = cyc;
          n++;
        end
      end
    join
    checks++;
    if (first !== tl[0] + 2)
      $display("FAIL single_latency: got %0d want %0d", first, tl[0] + 2);
    else passed++;
    checks++;
    if (n !== 32 || gaps !== 0)
      $display("FAIL single_burst: got n=%0d gaps=%0d want 32/0", n, gaps);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n = 0, first = -1, prev = -1, gaps = 0;
    beat_t o, e;
    tl.delete();
    fork
      drive(3, 0, 32, -400, 1'b0);
      for (int i = 0; i < 400 && n < 96; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL b2b_beat %0d: got %h want %h", n, o, e);
          else passed++;
          if (first < 0) first = cyc;
          else if (cyc != prev + 1) gaps++;
          prev = cyc;
          n++;
        end
      end
    join
    checks++;
    if (first !== tl[0] + 2)
      $display("FAIL b2b_latency: got %0d want %0d", first, tl[0] + 2);
    else passed++;
    checks++;
    if (prev !== tl[2] + 33)
      $display("FAIL b2b_last: got %0d want %0d", prev, tl[2] + 33);
    else passed++;
    checks++;
    if (n !== 96 || gaps !== 0)
      $display("FAIL b2b_burst: got n=%0d gaps=%0d want 96/0", n, gaps);
    else passed++;
  endtask

  task automatic test_gapped();
    int n = 0, first = -1, prev = -1, gaps = 0;
    beat_t o, e;
    tl.delete();
    fork
      drive(1, 1, 32, 500, 1'b0);
      for (int i = 0; i < 300 && n < 32; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL gap_beat %0d: got %h want %h", n, o, e);
          else passed++;
          if (first < 0) first = cyc;
          else if (cyc != prev + 1) gaps++;
          prev = cyc;
          n++;
        end
      end
    join
    checks++;
    if (first !== tl[0] + 2)
      $display("FAIL gap_latency: got %0d want %0d", first, tl[0] + 2);
    else passed++;
    checks++;
    if (n !== 32 || gaps !== 0)
      $display("FAIL gap_burst: got n=%0d gaps=%0d want 32/0", n, gaps);
    else passed++;
  endtask

  task automatic test_ce_hold();
    int n = 0, first = -1;
    bit froze = 1'b0;
    beat_t o, e;
    tl.delete();
    fork
      drive(1, 0, 32, 30, 1'b1);
      for (int i = 0; i < 300 && n < 32; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL ce_beat %0d: got %h want %h", n, o, e);
          else passed++;
          if (first < 0) first = cyc;
          n++;
          if (o.bin == 6'd20 && !froze) begin
            froze = 1'b1;
            ce = 1'b0;
            for (int j = 0; j < 5; j++) begin
              @(negedge CLK);
              checks++;
              if (obs() !== o || bus.valid_o !== 1'b1)
                $display("FAIL ce_freeze %0d: got %h v=%b want %h v=1",
                         j, obs(), bus.valid_o, o);
              else passed++;
            end
            ce = 1'b1;
          end
        end
      end
    join
    checks++;
    if (first !== tl[0] + 2 || n !== 32)
      $display("FAIL ce_frame: got first=%0d n=%0d want %0d/32",
               first, n, tl[0] + 2);
    else passed++;
  endtask

  task automatic test_reset_input();
    int n = 0, extra = 0;
    beat_t o, e;
    drive(1, 0, 10, 900, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0 || obs() !== '0)
      $display("FAIL rstin_outs: got v=%b %h want 0", bus.valid_o, obs());
    else passed++;
    tl.delete();
    fork
      drive(1, 0, 32, 300, 1'b0);
      for (int i = 0; i < 300 && n < 32; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL rstin_beat %0d: got %h want %h", n, o, e);
          else passed++;
          n++;
        end
      end
    join
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.valid_o) extra++;
    end
    checks++;
    if (n !== 32 || extra !== 0)
      $display("FAIL rstin_count: got n=%0d extra=%0d want 32/0", n, extra);
    else passed++;
  endtask

  task automatic test_reset_output();
    int extra = 0;
    bit hit = 1'b0;
    beat_t o, e;
    fork
      drive(1, 0, 32, 7, 1'b0);
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge CLK);
        if (ce && bus.valid_o) begin
          o = obs();
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          checks++;
          if (o !== e)
            $display("FAIL rstout_beat: got %h want %h", o, e);
          else passed++;
          if (o.bin == 6'd40) begin
            hit = 1'b1;
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            checks++;
            if (bus.valid_o !== 1'b0 || obs() !== '0)
              $display("FAIL rstout_outs: got v=%b %h want 0",
                       bus.valid_o, obs());
            else passed++;
          end
        end
      end
    join
    sb.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.valid_o) extra++;
    end
    checks++;
    if (!hit || extra !== 0)
      $display("FAIL rstout_idle: got hit=%b extra=%0d want 1/0", hit, extra);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.ar = '0;
    bus.ai = '0;
    bus.br = '0;
    bus.bi = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_ce_hold();
    test_reset_input();
    test_reset_output();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
